// File: rtl/rvga_mem_arbiter_pkg.sv
// Purpose: shared types for the fetch/data memory arbiter (word type, FSM states, grant id, request struct).
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package rvga_mem_arbiter_pkg;

    typedef logic [31:0] rvga_word;

    // Fixed state codes so the encoding stays stable for anything decoding it externally.
    localparam logic [1:0] ARB_ST_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ST_IBUSY = 2'd1;
    localparam logic [1:0] ARB_ST_DBUSY = 2'd2;
    localparam logic [1:0] ARB_ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ARB_ST_IDLE,
        IBUSY = ARB_ST_IBUSY,
        DBUSY = ARB_ST_DBUSY,
        DRAIN = ARB_ST_DRAIN
    } rvga_arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } rvga_arb_grant_e;

    // Registered memory-side request.
    typedef struct packed {
        logic     r_v;
        logic     w_v;
        rvga_word addr;
        rvga_word data;
    } rvga_mem_req_s;

    // Round-robin pick between two requesters: a lone requester wins outright,
    // on conflict the one that did not win last time wins.
    function automatic rvga_arb_grant_e rr_pick(input logic imem_req,
                                                input logic dmem_req,
                                                input rvga_arb_grant_e last);
        rvga_arb_grant_e pick;
        if (imem_req && dmem_req) begin
            pick = (last == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (dmem_req) begin
            pick = GRANT_D;
        end else begin
            pick = GRANT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rvga_rr_arb2.sv
// Purpose: two-input round-robin arbiter (fetch vs data) holding the last-grant flop.
// Latency: grant is combinational from the requests; last-grant updates on the clock edge when adv_i is high.
// Backpressure: none; the caller decides when a grant is taken by raising adv_i.
//
// Ports: clk_i/rst_i (sync active-high), imem_req_i/dmem_req_i requests,
//        adv_i commits the current grant, gnt_v_o any request present, gnt_o winner.
module rvga_rr_arb2
    import rvga_mem_arbiter_pkg::*;
#(
    parameter bit dmem_first_p = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            imem_req_i,
    input  logic            dmem_req_i,
    input  logic            adv_i,
    output logic            gnt_v_o,
    output rvga_arb_grant_e gnt_o
);

    rvga_arb_grant_e last_q;
    rvga_arb_grant_e last_d;

    always_comb begin
        gnt_v_o = imem_req_i | dmem_req_i;
        gnt_o   = rr_pick(imem_req_i, dmem_req_i, last_q);
        last_d  = last_q;
        if (adv_i && gnt_v_o) begin
            last_d = gnt_o;
        end
    end

    // Resetting last-grant to the opposite of the preferred port makes the
    // preferred port win the first conflict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= dmem_first_p ? GRANT_I : GRANT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rvga_mem_arbiter.sv
// Purpose: shares one level-request/pulse-response memory port between the fetch and data ports, one transaction at a time.
// Latency: request in cycle N -> registered mem request in N+1 -> requester response combinationally with mem_resp_v_i (min 2 cycles).
// Backpressure: requesters hold their request until their response; a DRAIN bubble follows every transaction; the watchdog aborts stalled ones.
//
// Ports: clk_i/rst_i (sync active-high); imem_* fetch port; dmem_* data port;
//        mem_* registered memory request and its response inputs;
//        timeout_o / proto_err_o sticky status flags, cleared only by reset.
module rvga_mem_arbiter
    import rvga_mem_arbiter_pkg::*;
#(
    parameter int unsigned timeout_p    = 1024,
    parameter bit          dmem_first_p = 1'b1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     imem_v_i,
    input  rvga_word imem_addr_i,
    output rvga_word imem_data_o,
    output logic     imem_resp_v_o,
    input  logic     dmem_r_v_i,
    input  logic     dmem_w_v_i,
    input  rvga_word dmem_addr_i,
    input  rvga_word dmem_data_i,
    output rvga_word dmem_data_o,
    output logic     dmem_resp_v_o,
    output logic     mem_r_v_o,
    output logic     mem_w_v_o,
    output rvga_word mem_addr_o,
    output rvga_word mem_data_o,
    input  rvga_word mem_data_i,
    input  logic     mem_resp_v_i,
    output logic     timeout_o,
    output logic     proto_err_o
);

    localparam int CNT_W = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = (timeout_p > 0) ? CNT_W'(timeout_p - 1) : '0;

    rvga_arb_state_e state_q, state_d;
    rvga_mem_req_s   req_q, req_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q, timeout_d;
    logic            proto_err_q, proto_err_d;

    logic            dmem_req;
    logic            arb_adv;
    logic            gnt_v;
    rvga_arb_grant_e gnt;
    logic            busy;
    logic            resp_fire;
    logic            wd_expire;

    assign dmem_req = dmem_r_v_i | dmem_w_v_i;

    rvga_rr_arb2 #(
        .dmem_first_p(dmem_first_p)
    ) u_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .imem_req_i (imem_v_i),
        .dmem_req_i (dmem_req),
        .adv_i      (arb_adv),
        .gnt_v_o    (gnt_v),
        .gnt_o      (gnt)
    );

    assign busy      = (state_q == IBUSY) || (state_q == DBUSY);
    assign resp_fire = busy && mem_resp_v_i;
    // A response in the final watchdog cycle still completes the transaction.
    assign wd_expire = (timeout_p != 0) && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
        proto_err_d = proto_err_q;
        arb_adv     = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_v) begin
                    arb_adv  = 1'b1;
                    wd_cnt_d = '0;
                    if (gnt == GRANT_D) begin
                        state_d    = DBUSY;
                        // Read+write together is illegal; the write wins.
                        req_d.w_v  = dmem_w_v_i;
                        req_d.r_v  = dmem_r_v_i & ~dmem_w_v_i;
                        req_d.addr = dmem_addr_i;
                        req_d.data = dmem_data_i;
                        if (dmem_r_v_i && dmem_w_v_i) begin
                            proto_err_d = 1'b1;
                        end
                    end else begin
                        state_d    = IBUSY;
                        req_d.r_v  = 1'b1;
                        req_d.w_v  = 1'b0;
                        req_d.addr = imem_addr_i;
                        req_d.data = '0;
                    end
                end
            end
            IBUSY, DBUSY: begin
                if (mem_resp_v_i) begin
                    req_d   = '0;
                    state_d = DRAIN;
                end else if (wd_expire) begin
                    // Abort silently; the requester is still holding its
                    // request and gets re-arbitrated after the bubble.
                    req_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign mem_r_v_o   = req_q.r_v;
    assign mem_w_v_o   = req_q.w_v;
    assign mem_addr_o  = req_q.addr;
    assign mem_data_o  = req_q.data;
    assign timeout_o   = timeout_q;
    assign proto_err_o = proto_err_q;

    // Responses are combinational so a requester can complete in the same
    // cycle memory answers; data is forced to zero outside a response.
    assign imem_resp_v_o = resp_fire && (state_q == IBUSY);
    assign dmem_resp_v_o = resp_fire && (state_q == DBUSY);
    assign imem_data_o   = imem_resp_v_o ? mem_data_i : '0;
    assign dmem_data_o   = (dmem_resp_v_o && !req_q.w_v) ? mem_data_i : '0;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Purpose: randomized scoreboard bench for rvga_mem_arbiter with a transaction-level grant/memory model.
// Latency: expects mem request one cycle after an idle issue, three cycles after the previous completion.
// Backpressure: requesters hold until their response; memory answers after 1..5 extra cycles or stays silent.
module tb_rvga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_v_i;
    logic [31:0] imem_addr_i;
    logic [31:0] imem_data_o;
    logic        imem_resp_v_o;
    logic        dmem_r_v_i;
    logic        dmem_w_v_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_data_i;
    logic [31:0] dmem_data_o;
    logic        dmem_resp_v_o;
    logic        mem_r_v_o;
    logic        mem_w_v_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_resp_v_i;
    logic        timeout_o;
    logic        proto_err_o;

    // Memory-side response comes from the model or from a deliberate stray pulse.
    logic        resp_mem;
    logic [31:0] mem_dat;
    logic        stray;
    logic [31:0] stray_dat;
    assign mem_resp_v_i = resp_mem | stray;
    assign mem_data_i   = resp_mem ? mem_dat : stray_dat;

    rvga_mem_arbiter #(
        .timeout_p   (8),
        .dmem_first_p(1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_v_i     (imem_v_i),
        .imem_addr_i  (imem_addr_i),
        .imem_data_o  (imem_data_o),
        .imem_resp_v_o(imem_resp_v_o),
        .dmem_r_v_i   (dmem_r_v_i),
        .dmem_w_v_i   (dmem_w_v_i),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_data_i  (dmem_data_i),
        .dmem_data_o  (dmem_data_o),
        .dmem_resp_v_o(dmem_resp_v_o),
        .mem_r_v_o    (mem_r_v_o),
        .mem_w_v_o    (mem_w_v_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_resp_v_i (mem_resp_v_i),
        .timeout_o    (timeout_o),
        .proto_err_o  (proto_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_d;
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          start_cyc;   // -1: follows another transaction of the same round
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   aborts = 0;
    bit   mem_en = 1'b1;
    int   fixed_lat = -1;
    bit   model_last = 1'b0;     // 0: fetch won last, 1: data won last

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Memory model: answers each new request after 1..5 cycles.
    initial begin
        bit r;
        bit rprev;
        int lat;
        logic [31:0] a;
        resp_mem = 1'b0;
        mem_dat  = '0;
        rprev    = 1'b0;
        forever begin
            @(negedge clk);
            r = mem_r_v_o | mem_w_v_o;
            if (r && !rprev && mem_en && !rst_i) begin
                lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 5);
                a   = mem_addr_o;
                repeat (lat) @(posedge clk);
                #1;
                resp_mem = 1'b1;
                mem_dat  = memfn(a);
                @(posedge clk);
                #1;
                resp_mem = 1'b0;
                mem_dat  = '0;
            end
            rprev = r;
        end
    end

    // Monitor: checks memory requests and requester responses against the scoreboard.
    initial begin
        bit   prev_req = 1'b0;
        bit   resp_prev = 1'b0;
        bit   tried = 1'b0;
        bit   req;
        int   run = 0;
        int   last_end = 0;
        int   exp_c;
        exp_t h;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_req  = 1'b0;
                resp_prev = 1'b0;
                tried     = 1'b0;
                run       = 0;
                continue;
            end
            req = mem_r_v_o | mem_w_v_o;
            if (!imem_resp_v_o) check("imem_data_idle", imem_data_o, 32'h0);
            if (!dmem_resp_v_o) check("dmem_data_idle", dmem_data_o, 32'h0);
            if (req && !prev_req) begin
                if (sb.size() == 0) begin
                    fails++;
                    tests++;
                    $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no request", mem_addr_o);
                end else begin
                    h     = sb[0];
                    exp_c = (!tried && h.start_cyc >= 0) ? h.start_cyc + 1 : last_end + 3;
                    check("req_cycle", 32'(cyc), 32'(exp_c));
                    check("req_addr", mem_addr_o, h.addr);
                    check("req_w", 32'(mem_w_v_o), 32'(h.w));
                    check("req_r", 32'(mem_r_v_o), 32'(!h.w));
                    if (h.w) check("req_wdata", mem_data_o, h.wdata);
                    tried = 1'b1;
                end
                run = 0;
            end
            if (req) run++;
            if (!req && prev_req && !resp_prev) begin
                aborts++;
                check("abort_len", 32'(run), 32'd8);
                check("abort_timeout_flag", 32'(timeout_o), 32'd1);
                last_end = cyc - 1;
            end
            if (imem_resp_v_o || dmem_resp_v_o) begin
                if (sb.size() == 0 || (imem_resp_v_o && dmem_resp_v_o)) begin
                    fails++;
                    tests++;
                    $display("FAIL unexpected_resp: got imem=%0b dmem=%0b, expected none", imem_resp_v_o, dmem_resp_v_o);
                end else begin
                    h = sb.pop_front();
                    check("resp_who", 32'(dmem_resp_v_o), 32'(h.is_d));
                    check("resp_data", h.is_d ? dmem_data_o : imem_data_o, h.w ? 32'h0 : memfn(h.addr));
                    tried    = 1'b0;
                    last_end = cyc;
                end
            end
            resp_prev = imem_resp_v_o | dmem_resp_v_o;
            prev_req  = req;
        end
    end

    // dk: 0 none, 1 read, 2 write, 3 read+write (illegal, expected as a write).
    task automatic issue(input bit ie, input logic [31:0] ia, input int dk,
                         input logic [31:0] da, input logic [31:0] dd);
        exp_t ei;
        exp_t ed;
        @(posedge clk);
        #1;
        ei = '{is_d: 1'b0, w: 1'b0, addr: ia, wdata: 32'h0, start_cyc: -1};
        ed = '{is_d: 1'b1, w: (dk >= 2), addr: da, wdata: dd, start_cyc: -1};
        if (ie && dk != 0) begin
            if (model_last == 1'b0) begin
                ed.start_cyc = cyc;
                sb.push_back(ed);
                sb.push_back(ei);
                model_last = 1'b0;
            end else begin
                ei.start_cyc = cyc;
                sb.push_back(ei);
                sb.push_back(ed);
                model_last = 1'b1;
            end
        end else if (ie) begin
            ei.start_cyc = cyc;
            sb.push_back(ei);
            model_last = 1'b0;
        end else begin
            ed.start_cyc = cyc;
            sb.push_back(ed);
            model_last = 1'b1;
        end
        imem_v_i    = ie;
        imem_addr_i = ia;
        dmem_r_v_i  = (dk == 1) || (dk == 3);
        dmem_w_v_i  = (dk >= 2);
        dmem_addr_i = da;
        dmem_data_i = dd;
    endtask

    task automatic wait_done(input int bound);
        bit di;
        bit dd;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            di = imem_resp_v_o;
            dd = dmem_resp_v_o;
            @(posedge clk);
            #1;
            if (di) imem_v_i = 1'b0;
            if (dd) begin
                dmem_r_v_i = 1'b0;
                dmem_w_v_i = 1'b0;
            end
            if (!imem_v_i && !dmem_r_v_i && !dmem_w_v_i) return;
        end
        fails++;
        tests++;
        $display("FAIL round_timeout: got requests still pending after %0d cycles, expected completion", bound);
        imem_v_i   = 1'b0;
        dmem_r_v_i = 1'b0;
        dmem_w_v_i = 1'b0;
        sb.delete();
    endtask

    initial begin
        bit ie;
        int dk;
        bit seen;
        rst_i       = 1'b1;
        imem_v_i    = 1'b0;
        imem_addr_i = '0;
        dmem_r_v_i  = 1'b0;
        dmem_w_v_i  = 1'b0;
        dmem_addr_i = '0;
        dmem_data_i = '0;
        stray       = 1'b0;
        stray_dat   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_r_v", 32'(mem_r_v_o), 32'd0);
        check("rst_mem_w_v", 32'(mem_w_v_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_data", mem_data_o, 32'h0);
        check("rst_resp", 32'({imem_resp_v_o, dmem_resp_v_o}), 32'd0);
        check("rst_flags", 32'({timeout_o, proto_err_o}), 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Directed: single fetch, two conflicting rounds (D,I,D,I), a data write.
        fixed_lat = 2;
        issue(1'b1, 32'h100, 0, 32'h0, 32'h0);
        wait_done(100);
        fixed_lat = -1;
        issue(1'b1, 32'h0, 1, 32'h2000, 32'h0);
        wait_done(100);
        issue(1'b1, 32'h0, 1, 32'h2000, 32'h0);
        wait_done(100);
        issue(1'b0, 32'h0, 2, 32'h3000, 32'h1234_5678);
        wait_done(100);

        for (int r = 0; r < 40; r++) begin
            ie = 1'($urandom_range(0, 1));
            dk = $urandom_range(0, 2);
            if (!ie && dk == 0) ie = 1'b1;
            issue(ie, $urandom & 32'hFFFF_FFFC, dk, $urandom & 32'hFFFF_FFFC, $urandom);
            wait_done(100);
        end

        // Stray response while idle.
        @(posedge clk);
        #1;
        stray     = 1'b1;
        stray_dat = 32'hCAFE_F00D;
        @(negedge clk);
        check("stray_resp", 32'({imem_resp_v_o, dmem_resp_v_o}), 32'd0);
        @(posedge clk);
        #1 stray = 1'b0;
        check("flags_before", 32'({timeout_o, proto_err_o}), 32'd0);

        // Read and write together: issued as a write, flag set.
        issue(1'b0, 32'h0, 3, 32'h5000, 32'hA5A5_0001);
        wait_done(100);
        check("proto_err", 32'(proto_err_o), 32'd1);

        // Watchdog: memory silent for the first attempt, answers the retry.
        mem_en = 1'b0;
        issue(1'b1, 32'h6000, 0, 32'h0, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = (aborts >= 1);
        end
        mem_en = 1'b1;
        wait_done(100);
        check("abort_count", 32'(aborts), 32'd1);
        check("timeout_sticky", 32'(timeout_o), 32'd1);

        // Reset during a data read, late response afterwards.
        mem_en = 1'b0;
        issue(1'b0, 32'h0, 1, 32'h4000, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = mem_r_v_o;
        end
        check("dbusy_reached", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        rst_i      = 1'b1;
        dmem_r_v_i = 1'b0;
        sb.delete();
        model_last = 1'b0;
        @(posedge clk);
        #1;
        rst_i     = 1'b0;
        stray     = 1'b1;
        stray_dat = 32'h1111_2222;
        @(negedge clk);
        check("rstmid_mem_r_v", 32'(mem_r_v_o), 32'd0);
        check("rstmid_mem_addr", mem_addr_o, 32'h0);
        check("rstmid_late_resp", 32'({imem_resp_v_o, dmem_resp_v_o}), 32'd0);
        check("rstmid_dmem_data", dmem_data_o, 32'h0);
        check("rstmid_flags", 32'({timeout_o, proto_err_o}), 32'd0);
        @(posedge clk);
        #1;
        stray  = 1'b0;
        mem_en = 1'b1;

        issue(1'b0, 32'h0, 1, 32'h4000, 32'h0);
        wait_done(100);
        for (int r = 0; r < 10; r++) begin
            ie = 1'($urandom_range(0, 1));
            dk = $urandom_range(0, 2);
            if (!ie && dk == 0) ie = 1'b1;
            issue(ie, $urandom & 32'hFFFF_FFFC, dk, $urandom & 32'hFFFF_FFFC, $urandom);
            wait_done(100);
        end
        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rvga_mem_arbiter.md
Name: rvga_mem_arbiter

Overview:
- Shares one external memory port (test_ddr-style level request / single-cycle response) between the core's instruction-fetch port and its data port.
- Sits between rvga_top and a single unified memory model, so the core runs on one memory instead of separate iddr/dddr instances.
- Only one transaction is outstanding at a time.
- Arbitration is round-robin on conflict. A watchdog releases the port if memory never responds.

Parameters:
- timeout_p, 1024: cycles a granted transaction may wait for mem_resp_v_i before it is aborted. 0 disables the watchdog.
- dmem_first_p, 1: which requester wins the first conflict after reset. 1 = data port, 0 = instruction port.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- imem_v_i  in  1  fetch request; held until imem_resp_v_o
- imem_addr_i  in  rvga_word  fetch address
- imem_data_o  out  rvga_word  fetch data; valid with imem_resp_v_o
- imem_resp_v_o  out  1  fetch response, one-cycle pulse
- dmem_r_v_i  in  1  data read request; held until dmem_resp_v_o
- dmem_w_v_i  in  1  data write request; held until dmem_resp_v_o
- dmem_addr_i  in  rvga_word  data address
- dmem_data_i  in  rvga_word  write data
- dmem_data_o  out  rvga_word  read data; valid with dmem_resp_v_o
- dmem_resp_v_o  out  1  data response, one-cycle pulse
- mem_r_v_o  out  1  memory read request (registered)
- mem_w_v_o  out  1  memory write request (registered)
- mem_addr_o  out  rvga_word  memory address (registered)
- mem_data_o  out  rvga_word  memory write data (registered)
- mem_data_i  in  rvga_word  memory read data
- mem_resp_v_i  in  1  memory response pulse
- timeout_o  out  1  sticky: a watchdog abort has occurred
- proto_err_o  out  1  sticky: dmem_r_v_i and dmem_w_v_i were seen high together

Behaviour:
- Reset values:
  - state = IDLE, last_grant = !dmem_first_p.
  - All mem_*_o = 0.
  - Both resp_v_o = 0; imem_data_o and dmem_data_o = 0.
  - timeout_o = 0, proto_err_o = 0, watchdog counter = 0.
- FSM states: IDLE, IBUSY, DBUSY, DRAIN.
- IDLE:
  - dmem request = dmem_r_v_i | dmem_w_v_i.
  - If only one requester is active, grant it.
  - If both are active, grant the one that did not win last_grant, then update last_grant.
  - On grant, register address, data and r/w for the granted requester into the mem_*_o registers. Go to IBUSY or DBUSY.
  - If both dmem_r_v_i and dmem_w_v_i are high at grant: perform a write and set proto_err_o.
- IBUSY / DBUSY:
  - mem_*_o stay stable.
  - When mem_resp_v_i = 1, in the same cycle (combinational):
    - Pulse the granted requester's resp_v_o.
    - Drive its data_o = mem_data_i; on a write, data_o = 0.
  - At that same clock edge, deassert mem_r_v_o/mem_w_v_o and go to DRAIN.
- DRAIN: one bubble cycle with all requests low, so the requester can drop or replace its request. Then go to IDLE.
- The non-granted requester sees no response. Its request is not latched; it is re-sampled in IDLE.
- Latency: request visible in cycle N → mem request in cycle N+1 → response in the same cycle as mem_resp_v_i. The minimum is 2 cycles. A sustained single requester gets one transaction per 3 cycles plus memory latency.
- Watchdog (timeout_p > 0):
  - The counter clears on grant and increments each cycle in IBUSY/DBUSY.
  - When count reaches timeout_p - 1 without a response: set timeout_o, give no requester response, drop the mem request, go to DRAIN.
  - The requester stays pending and is re-arbitrated later.
  - Counter width is $clog2(timeout_p+1).
- mem_resp_v_i outside IBUSY/DBUSY is ignored and produces no requester response.
- Requester data_o is 0 whenever its resp_v_o is 0.
- Reset mid-transaction: return to IDLE immediately and drop outputs. A memory response arriving afterwards is ignored.
- Sticky flags clear only on rst_i.

Decomposition:
- rvga_types gets:
  - enum rvga_arb_state_e {IDLE, IBUSY, DBUSY, DRAIN}
  - enum rvga_arb_grant_e {GRANT_I, GRANT_D}
  - a packed struct rvga_mem_req_s {r_v, w_v, addr, data} used for the registered memory request.
- Natural sub-module: rvga_rr_arb2, a 2-input round-robin arbiter holding the last_grant flop with an advance enable.
- The FSM, request mux and watchdog stay in the top module.

Test Plan:
- Single fetch:
  - Stimulus: imem_v_i=1, addr 0x100; memory responds 2 cycles after mem_r_v_o with 0xDEADBEEF.
  - Required: mem_addr_o=0x100 one cycle after the request; imem_resp_v_o pulses with 0xDEADBEEF; dmem_resp_v_o stays 0.
- Simultaneous requests after reset (dmem_first_p=1):
  - Stimulus: imem request addr 0x0 and data read addr 0x2000, both held.
  - Required: first grant to dmem (mem_addr_o=0x2000), second to imem (0x0). With both held, grants alternate D,I,D,I over 4 transactions.
- Data write:
  - Stimulus: dmem_w_v_i=1, addr 0x3000, data 0x12345678.
  - Required: mem_w_v_o=1, mem_data_o=0x12345678; dmem_resp_v_o pulses with dmem_data_o=0; mem_w_v_o=0 in the following DRAIN cycle.
- Watchdog (timeout_p=8):
  - Stimulus: memory never responds.
  - Required: after 8 busy cycles timeout_o=1 and mem_r_v_o drops; no requester response; request re-granted after DRAIN/IDLE.
- Protocol error and stray response:
  - Stimulus: dmem_r_v_i=dmem_w_v_i=1 → a write is issued and proto_err_o=1.
  - Stimulus: mem_resp_v_i pulse while in IDLE → no requester response.
- Reset mid-operation:
  - Stimulus: assert rst_i during DBUSY; memory responds the cycle after.
  - Required: all outputs 0 next cycle; the late response is ignored; the next request is granted normally.
